// File: rtl/req_grnt_arb_pkg.sv
// Shared types and default parameters for the round-robin request/grant arbiter.
package req_grnt_pkg;

  localparam int NUM_REQ_DEF  = 4;
  localparam int GNT_DLY_DEF  = 1;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_GRANT,
    ST_GAP
  } state_e;

endpackage

// File: rtl/req_grnt_arb_if.sv
// Request/grant bundle between requesters (master side) and the arbiter (slave side).
interface req_grnt_arb_if import req_grnt_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF
) ();

  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grnt;
  logic [IDW-1:0]     grnt_id;
  logic               busy;
  logic               timeout;

  modport master (output req, input grnt, grnt_id, busy, timeout);
  modport slave  (input req, output grnt, grnt_id, busy, timeout);

endinterface

// File: rtl/req_grnt_arb_rr_picker.sv
// Combinational round-robin search: first requester above last_winner, with wrap.
module rr_picker import req_grnt_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_winner,
  output logic               valid,
  output logic [IDW-1:0]     index
);

  always_comb begin
    valid = |req;
    index = '0;
    // Walk offsets from farthest to nearest so the nearest requester is assigned last.
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last_winner) + k) % NUM_REQ]) begin
        index = IDW'((int'(last_winner) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/req_grnt_arb.sv
// Round-robin request/grant arbiter with optional grant delay, hold limit and gap cycle.
module req_grnt_arb import req_grnt_pkg::*; #(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int GNT_DLY  = GNT_DLY_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input logic           clk,
  input logic           rst,
  req_grnt_arb_if.slave bus
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_e             state_q, state_d;
  logic [IDW-1:0]     winner_q, winner_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [7:0]         hold_q, hold_d;
  logic [NUM_REQ-1:0] grnt_q, grnt_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic               pick_vld;
  logic [IDW-1:0]     pick_idx;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_picker (
    .req         (bus.req),
    .last_winner (last_q),
    .valid       (pick_vld),
    .index       (pick_idx)
  );

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    last_d    = last_q;
    hold_d    = hold_q;
    grnt_d    = '0;
    timeout_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        hold_d = '0;
        if (pick_vld) begin
          winner_d = pick_idx;
          if (GNT_DLY == 1) begin
            state_d = ST_GRANT;
            grnt_d  = onehot(pick_idx);
            hold_d  = 8'd1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // A requester that withdraws before its grant forfeits the turn without moving the pointer.
        if (bus.req[winner_q]) begin
          state_d = ST_GRANT;
          grnt_d  = onehot(winner_q);
          hold_d  = 8'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (hold_q >= HOLD_MAX) begin
          state_d   = ST_GAP;
          timeout_d = 1'b1;
          hold_d    = '0;
        end else if (!bus.req[winner_q]) begin
          state_d = ST_GAP;
          hold_d  = '0;
        end else begin
          grnt_d = onehot(winner_q);
          hold_d = hold_q + 8'd1;
        end
      end
      ST_GAP: begin
        last_d  = winner_q;
        hold_d  = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      winner_q  <= '0;
      last_q    <= IDW'(NUM_REQ - 1);
      hold_q    <= '0;
      grnt_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      grnt_q    <= grnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grnt    = grnt_q;
  assign bus.grnt_id = winner_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_req_grnt_arb.sv
// Scoreboard bench: three arbiter configurations share req/rst and are checked against a behavioural model.
module tb_req_grnt_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_s = 4'b0000;

  always #5 clk = ~clk;

  req_grnt_arb_if #(.NUM_REQ(4)) if0 ();
  req_grnt_arb_if #(.NUM_REQ(4)) if1 ();
  req_grnt_arb_if #(.NUM_REQ(4)) if2 ();

  assign if0.req = req_s;
  assign if1.req = req_s;
  assign if2.req = req_s;

  req_grnt_arb #(.NUM_REQ(4), .GNT_DLY(1), .MAX_HOLD(8)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  req_grnt_arb #(.NUM_REQ(4), .GNT_DLY(2), .MAX_HOLD(8)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  req_grnt_arb #(.NUM_REQ(4), .GNT_DLY(1), .MAX_HOLD(1)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  typedef struct {
    int ptr;    // last requester that completed a grant
    int id;     // latched winner
    bit waiting;
    int held;   // cycles the grant has been high so far (0 = no grant)
    bit gap;
    bit to;
  } mdl_t;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } exp_t;

  mdl_t m0, m1, m2;
  exp_t q0[$], q1[$], q2[$];
  int   errors = 0;
  int   checks = 0;

  function automatic mdl_t mdl_reset();
    mdl_t n;
    n.ptr = 3; n.id = 0; n.waiting = 0; n.held = 0; n.gap = 0; n.to = 0;
    return n;
  endfunction

  function automatic mdl_t step(input mdl_t m, input logic [3:0] r, input bit rs,
                                input int dly, input int mh);
    mdl_t n;
    bit   found;
    n = m;
    n.to = 0;
    if (rs) return mdl_reset();
    if (m.gap) begin
      n.gap = 0;
      n.ptr = m.id;
    end else if (m.waiting) begin
      n.waiting = 0;
      if (r[m.id]) n.held = 1;
    end else if (m.held > 0) begin
      if (m.held >= mh) begin
        n.held = 0; n.gap = 1; n.to = 1;
      end else if (!r[m.id]) begin
        n.held = 0; n.gap = 1;
      end else begin
        n.held = m.held + 1;
      end
    end else if (r != 4'b0000) begin
      found = 0;
      for (int k = 1; k <= 4; k++) begin
        if (!found && r[(m.ptr + k) % 4]) begin
          n.id  = (m.ptr + k) % 4;
          found = 1;
        end
      end
      if (dly == 1) n.held = 1;
      else          n.waiting = 1;
    end
    return n;
  endfunction

  function automatic exp_t expv(input mdl_t m);
    exp_t e;
    e.g    = (m.held > 0) ? (4'b0001 << m.id) : 4'b0000;
    e.id   = 2'(m.id);
    e.busy = m.waiting || (m.held > 0) || m.gap;
    e.to   = m.to;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [3:0] r, input bit rs);
    @(negedge clk);
    req_s = r;
    rst   = rs;
    m0 = step(m0, r, rs, 1, 8);
    m1 = step(m1, r, rs, 2, 8);
    m2 = step(m2, r, rs, 1, 1);
    q0.push_back(expv(m0));
    q1.push_back(expv(m1));
    q2.push_back(expv(m2));
  endtask

  task automatic run(input logic [3:0] r, input int n);
    for (int i = 0; i < n; i++) cyc(r, 1'b0);
  endtask

  // Monitor: outputs are presented every cycle, so compare each cycle just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("d0.grnt", int'(if0.grnt), int'(e.g));
        chk("d0.grnt_id", int'(if0.grnt_id), int'(e.id));
        chk("d0.busy", int'(if0.busy), int'(e.busy));
        chk("d0.timeout", int'(if0.timeout), int'(e.to));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("d1.grnt", int'(if1.grnt), int'(e.g));
        chk("d1.grnt_id", int'(if1.grnt_id), int'(e.id));
        chk("d1.busy", int'(if1.busy), int'(e.busy));
        chk("d1.timeout", int'(if1.timeout), int'(e.to));
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        chk("d2.grnt", int'(if2.grnt), int'(e.g));
        chk("d2.grnt_id", int'(if2.grnt_id), int'(e.id));
        chk("d2.busy", int'(if2.busy), int'(e.busy));
        chk("d2.timeout", int'(if2.timeout), int'(e.to));
      end
    end
  end

  initial begin
    logic [3:0] r;
    bit         rs;
    m0 = mdl_reset();
    m1 = mdl_reset();
    m2 = mdl_reset();

    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    // Single request, then release.
    run(4'b0001, 4);
    run(4'b0000, 4);
    // Saturation across all four requesters.
    run(4'b1111, 50);
    run(4'b0000, 3);
    // Fairness: requester 1 wins, then 0110 must go to 2.
    cyc(4'b0000, 1'b1);
    run(4'b0010, 3);
    run(4'b0000, 4);
    run(4'b0110, 3);
    run(4'b0000, 4);
    // Abort in the delayed-grant configuration leaves the pointer at 1.
    cyc(4'b0000, 1'b1);
    run(4'b0010, 3);
    run(4'b0000, 4);
    run(4'b0100, 1);
    run(4'b0000, 3);
    run(4'b1111, 4);
    run(4'b0000, 4);
    // Reset in the third grant cycle.
    cyc(4'b0000, 1'b1);
    run(4'b0010, 3);
    cyc(4'b0010, 1'b1);
    run(4'b1111, 6);
    run(4'b0000, 4);
    // Held single request exercises re-grant after the hold limit.
    run(4'b0001, 24);
    run(4'b0000, 3);

    r = 4'b0000;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) r = 4'($urandom);
      rs = ($urandom_range(0, 59) == 0);
      cyc(r, rs);
    end
    run(4'b0000, 4);

    @(negedge clk);
    @(negedge clk);
    chk("sb.drained", q0.size() + q1.size() + q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
